// File: rtl/param_counter.sv
// Parametrised up/down/bounce counter with registered terminal-count pulse and direction.
// Define PARAM_COUNTER_GRAY_OUT_EN to add the Gray-coded count_gray output.
module param_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LIMIT    = 9,
    parameter int unsigned STEP     = 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       control,
    input  logic             init,
    input  logic [WIDTH-1:0] initialValue,
    output logic [WIDTH-1:0] count,
`ifdef PARAM_COUNTER_GRAY_OUT_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             dir,
    output logic             tc
);

    localparam int unsigned XW = WIDTH + 1;

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [XW-1:0]    LIMIT_X = XW'(LIMIT);
    localparam logic [XW-1:0]    STEP_X  = XW'(STEP);
    localparam logic [XW-1:0]    ONE_X   = XW'(1);

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_UP     = 2'b01;
    localparam logic [1:0] MODE_DOWN   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE = 2'b11;

    logic [WIDTH-1:0] count_q, count_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;

    logic [XW-1:0] count_x;
    logic [XW-1:0] sum_up;
    logic [XW-1:0] wrap_up;
    logic [XW-1:0] wrap_down;

    // Sums carried at WIDTH+1 bits so count+STEP cannot alias back into range.
    always_comb begin
        count_x   = {1'b0, count_q};
        sum_up    = count_x + STEP_X;
        wrap_up   = sum_up - LIMIT_X - ONE_X;
        wrap_down = count_x + (LIMIT_X + ONE_X - STEP_X);
    end

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;

        if (init) begin
            count_d = (initialValue > LIMIT_W) ? LIMIT_W : initialValue;
            dir_d   = 1'b0;
        end else begin
            unique case (control)
                MODE_HOLD: begin
                    count_d = count_q;
                end
                MODE_UP: begin
                    dir_d = 1'b0;
                    if (sum_up <= LIMIT_X) begin
                        count_d = WIDTH'(sum_up);
                    end else begin
                        tc_d    = 1'b1;
                        count_d = SATURATE ? LIMIT_W : WIDTH'(wrap_up);
                    end
                end
                MODE_DOWN: begin
                    dir_d = 1'b1;
                    if (count_q >= STEP_W) begin
                        count_d = count_q - STEP_W;
                    end else begin
                        tc_d    = 1'b1;
                        count_d = SATURATE ? '0 : WIDTH'(wrap_down);
                    end
                end
                MODE_BOUNCE: begin
                    // Direction is kept from the previous mode, so entry after a down run descends first.
                    if (!dir_q) begin
                        if (sum_up >= LIMIT_X) begin
                            count_d = LIMIT_W;
                            dir_d   = 1'b1;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = WIDTH'(sum_up);
                        end
                    end else begin
                        if (count_q <= STEP_W) begin
                            count_d = '0;
                            dir_d   = 1'b0;
                            tc_d    = 1'b1;
                        end else begin
                            count_d = count_q - STEP_W;
                        end
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign tc    = tc_q;

`ifdef PARAM_COUNTER_GRAY_OUT_EN
    assign count_gray = count_q ^ (count_q >> 1);
`endif

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: default wrap, saturate and bounce instances on one clock.
// Gray output checks are compiled in when PARAM_COUNTER_GRAY_OUT_EN is defined.
module tb_param_counter;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         d_rst, d_init, d_dir, d_tc;
    logic [1:0]   d_ctrl;
    logic [W-1:0] d_iv, d_count;
    logic         s_rst, s_init, s_dir, s_tc;
    logic [1:0]   s_ctrl;
    logic [W-1:0] s_iv, s_count;
    logic         b_rst, b_init, b_dir, b_tc;
    logic [1:0]   b_ctrl;
    logic [W-1:0] b_iv, b_count;
`ifdef PARAM_COUNTER_GRAY_OUT_EN
    logic [W-1:0] d_gray, s_gray, b_gray;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    param_counter #(.WIDTH(W), .LIMIT(9), .STEP(1), .SATURATE(1'b0)) u_def (
        .clk(clk), .rst(d_rst), .control(d_ctrl), .init(d_init), .initialValue(d_iv),
        .count(d_count),
`ifdef PARAM_COUNTER_GRAY_OUT_EN
        .count_gray(d_gray),
`endif
        .dir(d_dir), .tc(d_tc)
    );

    param_counter #(.WIDTH(W), .LIMIT(9), .STEP(1), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(s_rst), .control(s_ctrl), .init(s_init), .initialValue(s_iv),
        .count(s_count),
`ifdef PARAM_COUNTER_GRAY_OUT_EN
        .count_gray(s_gray),
`endif
        .dir(s_dir), .tc(s_tc)
    );

    param_counter #(.WIDTH(W), .LIMIT(9), .STEP(3), .SATURATE(1'b0)) u_bnc (
        .clk(clk), .rst(b_rst), .control(b_ctrl), .init(b_init), .initialValue(b_iv),
        .count(b_count),
`ifdef PARAM_COUNTER_GRAY_OUT_EN
        .count_gray(b_gray),
`endif
        .dir(b_dir), .tc(b_tc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_def(input string tag, input int c, input int dr, input int t);
        check({tag, ".count"}, 32'(d_count), 32'(c));
        check({tag, ".dir"},   32'(d_dir),   32'(dr));
        check({tag, ".tc"},    32'(d_tc),    32'(t));
    endtask

    task automatic chk_sat(input string tag, input int c, input int dr, input int t);
        check({tag, ".count"}, 32'(s_count), 32'(c));
        check({tag, ".dir"},   32'(s_dir),   32'(dr));
        check({tag, ".tc"},    32'(s_tc),    32'(t));
    endtask

    task automatic chk_bnc(input string tag, input int c, input int dr, input int t);
        check({tag, ".count"}, 32'(b_count), 32'(c));
        check({tag, ".dir"},   32'(b_dir),   32'(dr));
        check({tag, ".tc"},    32'(b_tc),    32'(t));
    endtask

    int up_cnt[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_cnt[5]   = '{2, 1, 0, 9, 8};
    int sat_cnt[4]  = '{8, 9, 9, 9};
    int sat_tc[4]   = '{0, 0, 1, 1};
    int bn_cnt[7]   = '{3, 6, 9, 6, 3, 0, 3};
    int bn_dir[7]   = '{0, 0, 1, 1, 1, 0, 0};
    int bn_tc[7]    = '{0, 0, 1, 0, 0, 1, 0};
    int gray_exp[10] = '{'h0, 'h1, 'h3, 'h2, 'h6, 'h7, 'h5, 'h4, 'hC, 'hD};

    initial begin
        d_rst = 1'b1; d_init = 1'b0; d_ctrl = 2'b00; d_iv = '0;
        s_rst = 1'b1; s_init = 1'b0; s_ctrl = 2'b00; s_iv = '0;
        b_rst = 1'b1; b_init = 1'b0; b_ctrl = 2'b00; b_iv = '0;

        // Reset, then wrap-around up count
        d_ctrl = 2'b01;
        tick();
        chk_def("rst", 0, 0, 0);
        d_rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk_def($sformatf("up%0d", i), up_cnt[i], 0, (i == 9) ? 1 : 0);
        end

        // Load then wrap-around down count
        d_init = 1'b1; d_iv = 4'd3;
        tick();
        chk_def("load3", 3, 0, 0);
        d_init = 1'b0; d_ctrl = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_def($sformatf("dn%0d", i), dn_cnt[i], 1, (i == 3) ? 1 : 0);
        end

        // Out-of-range load clamps to LIMIT and clears dir
        d_init = 1'b1; d_iv = 4'd14;
        tick();
        chk_def("load14", 9, 0, 0);

        // Hold keeps count and dir, never pulses tc
        d_iv = 4'd4;
        tick();
        d_init = 1'b0; d_ctrl = 2'b10;
        tick();
        chk_def("dn_pre_hold", 3, 1, 0);
        d_ctrl = 2'b00;
        tick();
        chk_def("hold0", 3, 1, 0);
        tick();
        chk_def("hold1", 3, 1, 0);

        // Reset beats init and control mid-count; boundary pulse is suppressed
        d_init = 1'b1; d_iv = 4'd5;
        tick();
        chk_def("load5", 5, 0, 0);
        d_rst = 1'b1; d_iv = 4'd7; d_ctrl = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_def($sformatf("rst_hold%0d", i), 0, 0, 0);
        end
        d_rst = 1'b0; d_iv = 4'd9;
        tick();
        chk_def("load9", 9, 0, 0);
        d_init = 1'b0; d_rst = 1'b1;
        tick();
        chk_def("rst_at_bound", 0, 0, 0);
        d_rst = 1'b0;

`ifdef PARAM_COUNTER_GRAY_OUT_EN
        d_ctrl = 2'b01;
        check("gray0", 32'(d_gray), 32'(gray_exp[0]));
        for (int i = 1; i < 10; i++) begin
            tick();
            check($sformatf("gray%0d", i), 32'(d_gray), 32'(gray_exp[i]));
        end
        d_ctrl = 2'b00;
`endif

        // Saturating instance: clamp at LIMIT with sustained tc, then hold
        tick();
        chk_sat("s_rst", 0, 0, 0);
        s_rst = 1'b0; s_init = 1'b1; s_iv = 4'd7;
        tick();
        chk_sat("s_load7", 7, 0, 0);
        s_init = 1'b0; s_ctrl = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_sat($sformatf("s_up%0d", i), sat_cnt[i], 0, sat_tc[i]);
        end
        s_ctrl = 2'b00;
        tick();
        chk_sat("s_hold", 9, 0, 0);
        s_init = 1'b1; s_iv = 4'd1;
        tick();
        s_init = 1'b0; s_ctrl = 2'b10;
        tick();
        chk_sat("s_dn0", 0, 1, 0);
        tick();
        chk_sat("s_dn_clamp", 0, 1, 1);

        // Bounce instance, STEP=3
        tick();
        chk_bnc("b_rst", 0, 0, 0);
        b_rst = 1'b0; b_ctrl = 2'b11;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk_bnc($sformatf("b%0d", i), bn_cnt[i], bn_dir[i], bn_tc[i]);
        end
        // Entering bounce after a down run keeps dir=1
        b_ctrl = 2'b10;
        tick();
        chk_bnc("b_dn", 0, 1, 0);
        b_ctrl = 2'b11;
        tick();
        chk_bnc("b_reenter", 0, 0, 1);
        tick();
        chk_bnc("b_after", 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
